// File: rtl/mdu_pkg.sv
// Shared types for the iterative multiply/divide unit: opcodes, FSM states and opcode classifiers.
package mdu_pkg;

  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MTHI  = 3'd4,
    MTLO  = 3'd5
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } mdu_state_t;

  function automatic logic isIterOp(input mdu_op_t op);
    return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
  endfunction

  function automatic logic isDivOp(input mdu_op_t op);
    return (op == DIV) || (op == DIVU);
  endfunction

  function automatic logic isSignedOp(input mdu_op_t op);
    return (op == MULT) || (op == DIV);
  endfunction

endpackage

// File: rtl/muldiv_iter_if.sv
// Execute-stage <-> multiply/divide unit connection: request side and HI/LO result side.
interface muldiv_iter_if import mdu_pkg::*; #(
  parameter int WIDTH = 32
) ();

  logic             start;
  mdu_op_t          op;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, srca, srcb, flush, input busy, done, hi, lo);
  modport slave  (input start, op, srca, srcb, flush, output busy, done, hi, lo);

endinterface

// File: rtl/muldiv_step.sv
// One UNROLL-wide iteration on unsigned magnitudes: shift-add multiply or restoring divide.
module muldiv_step #(
  parameter int WIDTH  = 32,
  parameter int UNROLL = 1
) (
  input  logic             isDiv,
  input  logic [WIDTH-1:0] accIn,
  input  logic [WIDTH-1:0] mqIn,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] accOut,
  output logic [WIDTH-1:0] mqOut
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mq;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  always_comb begin
    // NOTE: blocking assignments here chain the UNROLL steps; each pass reads the previous pass's result.
    acc     = accIn;
    mq      = mqIn;
    sum     = '0;
    shifted = '0;
    diff    = '0;
    for (int i = 0; i < UNROLL; i++) begin
      if (isDiv) begin
        // Remainder stays below the divisor, so a set top bit of diff can only mean a borrow.
        shifted = {acc, mq[WIDTH-1]};
        diff    = shifted - {1'b0, operand};
        if (!diff[WIDTH]) begin
          acc = diff[WIDTH-1:0];
          mq  = {mq[WIDTH-2:0], 1'b1};
        end else begin
          acc = shifted[WIDTH-1:0];
          mq  = {mq[WIDTH-2:0], 1'b0};
        end
      end else begin
        sum = {1'b0, acc} + (mq[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        acc = sum[WIDTH:1];
        mq  = {sum[0], mq[WIDTH-1:1]};
      end
    end
    accOut = acc;
    mqOut  = mq;
  end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit with architectural HI/LO; busy stalls later mult/div/HI/LO ops.
// Operands are iterated as magnitudes and the signs are applied in the single FIX cycle.
module muldiv_iter import mdu_pkg::*; #(
  parameter int WIDTH  = 32,
  parameter int UNROLL = 1
) (
  input  logic          clk,
  input  logic          reset,
  muldiv_iter_if.slave  bus
);

  localparam int N  = WIDTH / UNROLL;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if ((WIDTH % UNROLL) != 0) begin : gBadUnroll
    $error("muldiv_iter: UNROLL must divide WIDTH");
  end

  mdu_state_t       state;
  mdu_state_t       nextState;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mq;
  logic [WIDTH-1:0] operand;
  logic             isDiv;
  logic             negQuot;
  logic             negRem;
  logic             divZero;
  logic [WIDTH-1:0] hiQ;
  logic [WIDTH-1:0] loQ;
  logic             doneQ;

  logic             accept;
  logic             startIter;
  logic             startMove;
  logic [WIDTH-1:0] magA;
  logic [WIDTH-1:0] magB;
  logic [WIDTH-1:0] stepAcc;
  logic [WIDTH-1:0] stepMq;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0] resHi;
  logic [WIDTH-1:0] resLo;

  assign accept    = bus.start && !bus.flush && (state == IDLE);
  assign startIter = accept && isIterOp(bus.op);
  assign startMove = accept && ((bus.op == MTHI) || (bus.op == MTLO));

  assign magA = (isSignedOp(bus.op) && bus.srca[WIDTH-1]) ? -bus.srca : bus.srca;
  assign magB = (isSignedOp(bus.op) && bus.srcb[WIDTH-1]) ? -bus.srcb : bus.srcb;

  muldiv_step #(
    .WIDTH  (WIDTH),
    .UNROLL (UNROLL)
  ) uStep (
    .isDiv   (isDiv),
    .accIn   (acc),
    .mqIn    (mq),
    .operand (operand),
    .accOut  (stepAcc),
    .mqOut   (stepMq)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns nextState and no latch is inferred.
    nextState = state;
    case (state)
      IDLE:    if (startIter) nextState = RUN;
      RUN:     if (bus.flush) nextState = IDLE;
               else if (count == LAST) nextState = FIX;
      FIX:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Product and quotient share one sign; the remainder follows the dividend.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: datapath registers are reset too, so an op abandoned by reset leaves nothing behind.
      count   <= '0;
      acc     <= '0;
      mq      <= '0;
      operand <= '0;
      isDiv   <= 1'b0;
      negQuot <= 1'b0;
      negRem  <= 1'b0;
      divZero <= 1'b0;
    end else if (startIter) begin
      count   <= '0;
      acc     <= '0;
      mq      <= magA;
      operand <= magB;
      isDiv   <= isDivOp(bus.op);
      negQuot <= isSignedOp(bus.op) && (bus.srca[WIDTH-1] ^ bus.srcb[WIDTH-1]);
      negRem  <= isSignedOp(bus.op) && bus.srca[WIDTH-1];
      divZero <= (bus.srcb == '0);
    end else if (state == RUN) begin
      count <= count + 1'b1;
      acc   <= stepAcc;
      mq    <= stepMq;
    end
  end

  assign product = negQuot ? -{acc, mq} : {acc, mq};

  // Divide by zero leaves the dividend in acc naturally; only the quotient needs forcing.
  always_comb begin
    resHi = product[2*WIDTH-1:WIDTH];
    resLo = product[WIDTH-1:0];
    if (isDiv) begin
      resHi = negRem ? -acc : acc;
      resLo = divZero ? '1 : (negQuot ? -mq : mq);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hiQ   <= '0;
      loQ   <= '0;
      doneQ <= 1'b0;
    end else begin
      doneQ <= 1'b0;
      if ((state == FIX) && !bus.flush) begin
        hiQ   <= resHi;
        loQ   <= resLo;
        doneQ <= 1'b1;
      end else if (startMove) begin
        if (bus.op == MTHI) hiQ <= bus.srca;
        else                loQ <= bus.srca;
      end
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = doneQ;
  assign bus.hi   = hiQ;
  assign bus.lo   = loQ;

endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter at UNROLL=1 and UNROLL=4 with a result scoreboard.
module tb_muldiv_iter;
  import mdu_pkg::*;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } result_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  result_t sb1[$];
  result_t sb4[$];

  always #5 clk = ~clk;

  muldiv_iter_if #(.WIDTH(W)) bus1 ();
  muldiv_iter_if #(.WIDTH(W)) bus4 ();

  muldiv_iter #(.WIDTH(W), .UNROLL(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  muldiv_iter #(.WIDTH(W), .UNROLL(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

  function automatic logic getBusy(input int d);
    return (d == 1) ? bus1.busy : bus4.busy;
  endfunction

  function automatic logic getDone(input int d);
    return (d == 1) ? bus1.done : bus4.done;
  endfunction

  function automatic logic [W-1:0] getHi(input int d);
    return (d == 1) ? bus1.hi : bus4.hi;
  endfunction

  function automatic logic [W-1:0] getLo(input int d);
    return (d == 1) ? bus1.lo : bus4.lo;
  endfunction

  // Reference model built on the simulator's own arithmetic.
  function automatic result_t model(input mdu_op_t o, input logic [W-1:0] a, input logic [W-1:0] b);
    result_t      r;
    longint       sa, sb, q, m;
    logic [2*W-1:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = '0;
    case (o)
      MULT: begin
        p = sa * sb;
        r = result_t'(p);
      end
      MULTU: begin
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        r = result_t'(p);
      end
      DIVU: begin
        if (b == '0) begin r.hi = a; r.lo = '1; end
        else begin r.lo = a / b; r.hi = a % b; end
      end
      DIV: begin
        if (b == '0) begin
          r.hi = a; r.lo = '1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          r.hi = '0; r.lo = a;
        end else begin
          q = sa / sb;
          m = sa % sb;
          r.lo = q[W-1:0];
          r.hi = m[W-1:0];
        end
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic drive(input int d, input logic s, input mdu_op_t o,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic f);
    if (d == 1) begin
      bus1.start = s; bus1.op = o; bus1.srca = a; bus1.srcb = b; bus1.flush = f;
    end else begin
      bus4.start = s; bus4.op = o; bus4.srca = a; bus4.srcb = b; bus4.flush = f;
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the sampling edge.
  task automatic issue(input int d, input mdu_op_t o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit push);
    drive(d, 1'b1, o, a, b, 1'b0);
    if (push) begin
      if (d == 1) sb1.push_back(model(o, a, b));
      else        sb4.push_back(model(o, a, b));
    end
    @(negedge clk);
    drive(d, 1'b0, o, a, b, 1'b0);
  endtask

  // Waits for done, then pops the scoreboard and checks result, latency and busy length.
  task automatic scoreDone(input int d, input string name, input int lat0);
    int      lat;
    int      busyCycles;
    int      expLat;
    result_t exp;
    lat        = lat0;
    busyCycles = lat0;
    expLat     = W / d + 1;
    while (getDone(d) !== 1'b1 && lat < 200) begin
      if (getBusy(d) === 1'b1) busyCycles++;
      @(negedge clk);
      lat++;
    end
    checks++;
    if (getDone(d) !== 1'b1) begin
      failures++;
      $display("FAIL %s timeout: done=%b after %0d cycles, required 1", name, getDone(d), lat);
    end
    checks++;
    if ((d == 1 && sb1.size() == 0) || (d == 4 && sb4.size() == 0)) begin
      failures++;
      $display("FAIL %s scoreboard: no expected entry for this result", name);
      return;
    end
    if (d == 1) exp = sb1.pop_front();
    else        exp = sb4.pop_front();
    checks++;
    if (getHi(d) !== exp.hi) begin
      failures++;
      $display("FAIL %s hi: got %h required %h", name, getHi(d), exp.hi);
    end
    checks++;
    if (getLo(d) !== exp.lo) begin
      failures++;
      $display("FAIL %s lo: got %h required %h", name, getLo(d), exp.lo);
    end
    checks++;
    if (lat != expLat) begin
      failures++;
      $display("FAIL %s latency: got %0d required %0d", name, lat, expLat);
    end
    checks++;
    if (busyCycles != expLat || getBusy(d) !== 1'b0) begin
      failures++;
      $display("FAIL %s busy: high %0d cycles (busy now %b), required %0d then 0",
               name, busyCycles, getBusy(d), expLat);
    end
  endtask

  task automatic test_reset();
    #12;
    for (int i = 0; i < 2; i++) begin
      int d;
      d = (i == 0) ? 1 : 4;
      checks++;
      if ({getBusy(d), getDone(d), getHi(d), getLo(d)} !== '0) begin
        failures++;
        $display("FAIL reset_state u%0d: busy=%b done=%b hi=%h lo=%h required all 0",
                 d, getBusy(d), getDone(d), getHi(d), getLo(d));
      end
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_multiply();
    issue(1, MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    scoreDone(1, "multu_max", 0);
    @(negedge clk);
    checks++;
    if (getDone(1) !== 1'b0) begin
      failures++;
      $display("FAIL done_pulse: got %b one cycle after done, required 0", getDone(1));
    end
    issue(1, MULT, 32'hFFFF_FFF9, 32'd3, 1'b1);
    scoreDone(1, "mult_neg7x3", 0);
    issue(1, MULT, 32'h8000_0000, 32'h8000_0000, 1'b1);
    scoreDone(1, "mult_minxmin", 0);
    for (int i = 0; i < 4; i++) begin
      issue(1, (i % 2 == 0) ? MULT : MULTU, $urandom(), $urandom(), 1'b1);
      scoreDone(1, "mult_random", 0);
    end
  endtask

  task automatic test_divide();
    issue(1, DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
    scoreDone(1, "div_neg7by2", 0);
    issue(1, DIVU, 32'd100, 32'd0, 1'b1);
    scoreDone(1, "divu_by_zero", 0);
    issue(1, DIV, 32'hFFFF_FFFB, 32'd0, 1'b1);
    scoreDone(1, "div_neg_by_zero", 0);
    issue(1, DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    scoreDone(1, "div_overflow", 0);
    issue(1, DIV, 32'd7, 32'hFFFF_FFFE, 1'b1);
    scoreDone(1, "div_7by_neg2", 0);
    for (int i = 0; i < 4; i++) begin
      issue(1, (i % 2 == 0) ? DIV : DIVU, $urandom(), $urandom_range(1, 5000), 1'b1);
      scoreDone(1, "div_random", 0);
    end
  endtask

  task automatic test_move();
    drive(1, 1'b1, MTHI, 32'h1234, '0, 1'b0);
    @(negedge clk);
    checks++;
    if (getHi(1) !== 32'h1234 || getBusy(1) !== 1'b0 || getDone(1) !== 1'b0) begin
      failures++;
      $display("FAIL mthi: hi=%h busy=%b done=%b required 00001234 0 0", getHi(1), getBusy(1), getDone(1));
    end
    drive(1, 1'b1, MTLO, 32'h5678, '0, 1'b0);
    @(negedge clk);
    drive(1, 1'b0, MTLO, 32'h5678, '0, 1'b0);
    checks++;
    if (getHi(1) !== 32'h1234 || getLo(1) !== 32'h5678 || getBusy(1) !== 1'b0 || getDone(1) !== 1'b0) begin
      failures++;
      $display("FAIL mtlo: hi=%h lo=%h busy=%b done=%b required 00001234 00005678 0 0",
               getHi(1), getLo(1), getBusy(1), getDone(1));
    end
    issue(1, MULTU, 32'd5, 32'd6, 1'b1);
    repeat (4) @(negedge clk);
    drive(1, 1'b1, MTHI, 32'hDEAD, 32'hBEEF, 1'b0);
    @(negedge clk);
    drive(1, 1'b0, MULT, '0, '0, 1'b0);
    checks++;
    if (getHi(1) !== 32'h1234 || getLo(1) !== 32'h5678 || getBusy(1) !== 1'b1) begin
      failures++;
      $display("FAIL start_while_busy: hi=%h lo=%h busy=%b required 00001234 00005678 1",
               getHi(1), getLo(1), getBusy(1));
    end
    scoreDone(1, "multu_after_ignored_start", 5);
  endtask

  task automatic test_flush();
    bit sawDone;
    drive(1, 1'b1, MTHI, 32'hA, '0, 1'b0);
    @(negedge clk);
    drive(1, 1'b1, MTLO, 32'hB, '0, 1'b0);
    @(negedge clk);
    drive(1, 1'b0, MULT, '0, '0, 1'b0);
    issue(1, MULT, 32'd5, 32'd6, 1'b0);
    repeat (10) @(negedge clk);
    drive(1, 1'b0, MULT, 32'd5, 32'd6, 1'b1);
    @(negedge clk);
    drive(1, 1'b0, MULT, 32'd5, 32'd6, 1'b0);
    checks++;
    if (getBusy(1) !== 1'b0) begin
      failures++;
      $display("FAIL flush_busy: got %b required 0", getBusy(1));
    end
    sawDone = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (getDone(1) !== 1'b0) sawDone = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (sawDone || getHi(1) !== 32'hA || getLo(1) !== 32'hB) begin
      failures++;
      $display("FAIL flush_result: sawDone=%b hi=%h lo=%h required 0 0000000a 0000000b",
               sawDone, getHi(1), getLo(1));
    end
    drive(1, 1'b1, MTHI, 32'h99, '0, 1'b1);
    @(negedge clk);
    checks++;
    if (getHi(1) !== 32'hA) begin
      failures++;
      $display("FAIL flush_idle_mthi: hi=%h required 0000000a", getHi(1));
    end
    drive(1, 1'b1, MULT, 32'd5, 32'd6, 1'b1);
    @(negedge clk);
    drive(1, 1'b0, MULT, '0, '0, 1'b0);
    checks++;
    if (getBusy(1) !== 1'b0) begin
      failures++;
      $display("FAIL flush_idle_start: busy=%b required 0", getBusy(1));
    end
  endtask

  task automatic test_reset_mid_op();
    drive(1, 1'b1, MTHI, 32'h55, '0, 1'b0);
    @(negedge clk);
    drive(1, 1'b0, MULT, '0, '0, 1'b0);
    issue(1, DIV, 32'd1000, 32'd7, 1'b0);
    repeat (5) @(negedge clk);
    checks++;
    if (getBusy(1) !== 1'b1 || getHi(1) !== 32'h55) begin
      failures++;
      $display("FAIL pre_reset: busy=%b hi=%h required 1 00000055", getBusy(1), getHi(1));
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({getBusy(1), getDone(1), getHi(1), getLo(1)} !== '0) begin
      failures++;
      $display("FAIL reset_mid_div: busy=%b done=%b hi=%h lo=%h required all 0",
               getBusy(1), getDone(1), getHi(1), getLo(1));
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back(input int d);
    issue(d, DIVU, 32'd17, 32'd5, 1'b1);
    scoreDone(d, (d == 1) ? "b2b_divu_u1" : "b2b_divu_u4", 0);
    issue(d, MULTU, 32'd3, 32'd4, 1'b1);
    scoreDone(d, (d == 1) ? "b2b_multu_u1" : "b2b_multu_u4", 0);
    if (d == 4) begin
      issue(d, MULT, 32'hFFFF_FFF9, 32'd3, 1'b1);
      scoreDone(d, "b2b_mult_u4", 0);
      issue(d, DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      scoreDone(d, "b2b_div_overflow_u4", 0);
      issue(d, DIV, $urandom(), $urandom_range(1, 300), 1'b1);
      scoreDone(d, "b2b_div_random_u4", 0);
    end
  endtask

  initial begin
    reset = 1'b0;
    drive(1, 1'b0, MULT, '0, '0, 1'b0);
    drive(4, 1'b0, MULT, '0, '0, 1'b0);
    test_reset();
    test_multiply();
    test_divide();
    test_move();
    test_flush();
    test_reset_mid_op();
    test_back_to_back(1);
    test_back_to_back(4);
    checks++;
    if (sb1.size() != 0 || sb4.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d/%0d entries left, required 0/0", sb1.size(), sb4.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
